// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: request/size/response codes,
// FSM states and lane helpers.
package dmem_responder_pkg;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmr_state_e;

    // Byte lanes touched by an access of the given size, before alignment shift.
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        logic [7:0] mask;
        unique case (size)
            SIZE_B:  mask = 8'h01;
            SIZE_H:  mask = 8'h03;
            SIZE_W:  mask = 8'h0f;
            default: mask = 8'hff;
        endcase
        return mask;
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] mask;
        unique case (size)
            SIZE_B:  mask = 3'b000;
            SIZE_H:  mask = 3'b001;
            SIZE_W:  mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_ram_1rw.sv
// Single-port DEPTH x 64 SRAM with per-byte write enables and a registered read port.
module dmem_ram_1rw #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    be,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 8; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed latency, byte-enabled backing SRAM.
// Optional address/alignment error checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_req,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [1:0]  mem_size,
    output logic        mem_ready,
    output logic [1:0]  mem_resp,
    output logic [63:0] mem_rdata
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    dmr_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  resp_q, resp_d;
    logic        rvalid_q, rvalid_d;

    logic        req_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [1:0]  size_q;

    logic [1:0]  err_resp;
    logic        access;
    logic        ram_en;
    logic [7:0]  ram_be;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (mem_valid) state_d = StWait;
            StWait:  if (cnt_q == 4'd0) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counter and registered response fields
    always_comb begin
        cnt_d    = cnt_q;
        resp_d   = RESP_OKAY;
        rvalid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_valid) cnt_d = LAT;
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_d   = err_resp;
                    rvalid_d = (err_resp == RESP_OKAY) && (req_q == REQ_READ);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q    <= 4'd0;
            resp_q   <= RESP_OKAY;
            rvalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Request fields are captured once; later changes on the port are ignored.
    always_ff @(posedge clock) begin
        if (reset && state_q == StIdle && mem_valid) begin
            req_q   <= mem_req;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            size_q  <= mem_size;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    always_comb begin
        err_resp = RESP_OKAY;
        if (|addr_q[63:3+AW]) begin
            err_resp = RESP_DECERR;
        end else if (|(addr_q[2:0] & align_mask(size_q))) begin
            err_resp = RESP_SLVERR;
        end
    end
`else
    // Upper address bits wrap modulo DEPTH when checking is disabled.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[63:3+AW];
    assign err_resp       = RESP_OKAY;
`endif

    // Lanes past the 8-byte boundary fall off the top of the shift.
    assign access    = (state_q == StWait) && (cnt_q == 4'd0);
    assign ram_en    = access && reset && (err_resp == RESP_OKAY);
    assign ram_be    = lane_mask(size_q) << addr_q[2:0];
    assign ram_wdata = wdata_q << {addr_q[2:0], 3'b000};

    dmem_ram_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (req_q == REQ_WRITE),
        .addr  (addr_q[3+AW-1:3]),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Outputs
    always_comb begin
        mem_ready = (state_q == StResp);
        mem_resp  = resp_q;
        mem_rdata = rvalid_q ? ram_rdata : 64'd0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned AW      = $clog2(DEPTH);

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_req = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [1:0]  mem_size = '0;
    logic        mem_ready;
    logic [1:0]  mem_resp;
    logic [63:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mdl [DEPTH*8];

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_ready (mem_ready),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [63:0] addr, input logic [1:0] size);
`ifdef DMEM_ERR_CHECK_EN
        if (addr >= 64'(DEPTH * 8)) return RESP_DECERR;
        if ((addr % (64'd1 << size)) != 64'd0) return RESP_SLVERR;
`endif
        return RESP_OKAY;
    endfunction

    // Applies a request to the byte-array model; returns expected rdata and resp.
    task automatic model_apply(input logic req, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [1:0] size, output logic [63:0] exp_rd,
                               output logic [1:0] exp_rs);
        int base, off, nb;
        exp_rs = exp_resp(addr, size);
        exp_rd = '0;
        if (exp_rs != RESP_OKAY) return;
        base = int'((addr >> 3) % DEPTH) * 8;
        off  = int'(addr % 8);
        nb   = 1 << size;
        if (req == REQ_WRITE) begin
            for (int i = 0; i < nb; i++) begin
                if (off + i < 8) mdl[base + off + i] = wdata[8*i +: 8];
            end
        end else begin
            for (int b = 0; b < 8; b++) exp_rd[8*b +: 8] = mdl[base + b];
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the post-RESP edge.
    task automatic do_req(input logic req, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] size, input string tag, output logic [63:0] got);
        logic [63:0] e_rd;
        logic [1:0]  e_rs;
        int cyc;
        model_apply(req, addr, wdata, size, e_rd, e_rs);
        mem_valid = 1'b1;
        mem_req   = req;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_size  = size;
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
        end while (!mem_ready && cyc < 40);
        check_val({tag, " latency"}, 64'(cyc), 64'(LATENCY + 2));
        check_val({tag, " resp"}, 64'(mem_resp), 64'(e_rs));
        check_val({tag, " rdata"}, mem_rdata, e_rd);
        got = mem_rdata;
        mem_valid = 1'b0;
        @(posedge clock);
        #1;
        check_val({tag, " ready drop"}, 64'(mem_ready), 64'd0);
        check_val({tag, " rdata clr"}, mem_rdata, 64'd0);
        check_val({tag, " resp clr"}, 64'(mem_resp), 64'(RESP_OKAY));
    endtask

    initial begin
        logic [63:0] got, e_rd, addr, upper;
        logic [1:0]  e_rs, size;
        logic        req;
        int          pulses, no_ready;

        repeat (2) @(posedge clock);
        #1;
        check_val("reset ready", 64'(mem_ready), 64'd0);
        check_val("reset resp", 64'(mem_resp), 64'(RESP_OKAY));
        check_val("reset rdata", mem_rdata, 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int w = 0; w < 32; w++) do_req(REQ_WRITE, 64'(w * 8), 64'd0, SIZE_D, "init", got);

        do_req(REQ_WRITE, 64'h10, 64'h1122334455667788, SIZE_D, "t1 wr", got);
        do_req(REQ_READ, 64'h10, 64'd0, SIZE_D, "t1 rd", got);
        check_val("t1 literal", got, 64'h1122334455667788);

        do_req(REQ_WRITE, 64'h10, 64'd0, SIZE_D, "t2 clr", got);
        do_req(REQ_WRITE, 64'h13, 64'hab, SIZE_B, "t2 wr", got);
        do_req(REQ_READ, 64'h10, 64'd0, SIZE_D, "t2 rd", got);
        check_val("t2 literal", got, 64'h00000000ab000000);

        do_req(REQ_WRITE, 64'h16, 64'hbeef, SIZE_H, "t3 wr", got);
        do_req(REQ_READ, 64'h10, 64'd0, SIZE_D, "t3 rd", got);
        check_val("t3 literal", got, 64'hbeef0000ab000000);

        do_req(REQ_READ, 64'h02, 64'd0, SIZE_W, "t4 misalign", got);
        do_req(REQ_READ, 64'(DEPTH * 8), 64'd0, SIZE_D, "t4 range", got);
        do_req(REQ_WRITE, 64'(DEPTH * 8) + 64'h10, 64'hcafe, SIZE_D, "t4 wr hi", got);
        do_req(REQ_READ, 64'h10, 64'd0, SIZE_D, "t4 rd back", got);

        // valid held across back-to-back reads: one pulse per request, LATENCY+3 apart
        model_apply(REQ_READ, 64'h10, 64'd0, SIZE_D, e_rd, e_rs);
        mem_valid = 1'b1;
        mem_req   = REQ_READ;
        mem_addr  = 64'h10;
        mem_size  = SIZE_D;
        pulses = 0;
        for (int k = 1; k <= 3 * (LATENCY + 3) + 2; k++) begin
            @(posedge clock);
            #1;
            if (mem_ready) begin
                check_val("b2b pos", 64'(k), 64'(pulses * (LATENCY + 3) + LATENCY + 2));
                check_val("b2b rdata", mem_rdata, e_rd);
                pulses++;
                if (pulses == 3) mem_valid = 1'b0;
            end
        end
        check_val("b2b pulses", 64'(pulses), 64'd3);

        // reset during WAIT of a write must abandon it
        mem_valid = 1'b1;
        mem_req   = REQ_WRITE;
        mem_addr  = 64'h10;
        mem_wdata = 64'hdeadbeef01234567;
        mem_size  = SIZE_D;
        @(posedge clock);
        #1;
        mem_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_val("rst ready", 64'(mem_ready), 64'd0);
        check_val("rst resp", 64'(mem_resp), 64'(RESP_OKAY));
        check_val("rst rdata", mem_rdata, 64'd0);
        reset = 1'b1;
        no_ready = 0;
        for (int k = 0; k < LATENCY + 4; k++) begin
            @(posedge clock);
            #1;
            if (mem_ready) no_ready++;
        end
        check_val("rst no pulse", 64'(no_ready), 64'd0);
        do_req(REQ_READ, 64'h10, 64'd0, SIZE_D, "rst rd", got);

        for (int n = 0; n < 300; n++) begin
            upper = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'($urandom)} : 64'd0;
            addr  = (upper << (3 + AW)) | 64'($urandom_range(0, 31) << 3)
                  | 64'($urandom_range(0, 7));
            size  = 2'($urandom_range(0, 3));
            req   = 1'($urandom_range(0, 1));
            do_req(req, addr, {32'($urandom), 32'($urandom)}, size, "rand", got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
